led_trail_pwm: RTL and testbench

LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

---
 rtl/led_trail_pwm.sv | 72 +++++++
 tb/tb_led_trail_pwm.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/led_trail_pwm.sv
// LED chaser trail: each lit channel jumps to full brightness, then fades in
// DECAY_STEP steps per prescaler tick, rendered as active-low PWM per channel.
module led_trail_pwm #(
  parameter int NUMBER_OF_LEDS = 6,
  parameter int PWM_BITS       = 8,
  parameter int DECAY_CYCLES   = 'd135000,
  parameter int DECAY_STEP     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUMBER_OF_LEDS-1:0] pattern_in,
  output logic [NUMBER_OF_LEDS-1:0] led
);

  localparam int PRESC_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DECAY_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);

  logic [NUMBER_OF_LEDS-1:0] pattern_q, pattern_d;
  logic [PRESC_W-1:0]        presc_q, presc_d;
  logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]       level_q [NUMBER_OF_LEDS];
  logic [PWM_BITS-1:0]       level_d [NUMBER_OF_LEDS];
  logic [NUMBER_OF_LEDS-1:0] led_q, led_d;
  logic                      tick_s;

  // Next-state logic for prescaler, PWM counter, levels and LED drive.
  always_comb begin
    pattern_d = pattern_in;
    tick_s    = (presc_q == PRESC_LAST);
    presc_d   = tick_s ? {PRESC_W{1'b0}} : presc_q + PRESC_W'(1);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    level_d   = level_q;
    led_d     = led_q;
    for (int i = 0; i < NUMBER_OF_LEDS; i++) begin
      // A lit input wins over a decay tick in the same cycle.
      if (!pattern_q[i]) begin
        level_d[i] = LEVEL_MAX;
      end else if (tick_s) begin
        level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : {PWM_BITS{1'b0}};
      end else begin
        level_d[i] = level_q[i];
      end
      led_d[i] = !((level_q[i] == LEVEL_MAX) || (pwm_cnt_q < level_q[i]));
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= {NUMBER_OF_LEDS{1'b1}};
      presc_q   <= {PRESC_W{1'b0}};
      pwm_cnt_q <= {PWM_BITS{1'b0}};
      led_q     <= {NUMBER_OF_LEDS{1'b1}};
      for (int i = 0; i < NUMBER_OF_LEDS; i++) begin
        level_q[i] <= {PWM_BITS{1'b0}};
      end
    end else begin
      pattern_q <= pattern_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      for (int i = 0; i < NUMBER_OF_LEDS; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm (6 LEDs, 4-bit PWM, 64-cycle tick, step 4).
module tb_led_trail_pwm;

  localparam int N = 6;

  logic         clk;
  logic         rst;
  logic [N-1:0] pattern_in;
  logic [N-1:0] led;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int errs;
  int others;
  int lows [N];
  int decay_lvl [5] = '{11, 7, 3, 0, 0};
  int trail_lvl [6] = '{16, 11, 7, 3, 0, 0};
  logic [N-1:0] pat;

  led_trail_pwm #(
    .NUMBER_OF_LEDS(6),
    .PWM_BITS(4),
    .DECAY_CYCLES(64),
    .DECAY_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pattern_in(pattern_in),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // cyc = number of edges since the last reset release
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic window16();
    for (int j = 0; j < N; j++) lows[j] = 0;
    repeat (16) begin
      step();
      for (int j = 0; j < N; j++) if (!led[j]) lows[j]++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    pattern_in = 6'b111110;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_led_%0d", i), int'(led), 32'h3f);
    end

    // three-edge latency after reset release
    rst = 1'b0;
    cyc = 0;
    step();
    check("lat_e1", int'(led), 32'h3f);
    step();
    check("lat_e2", int'(led), 32'h3f);
    step();
    check("lat_e3", int'(led), 32'h3e);

    errs = 0;
    while (cyc < 200) begin
      step();
      if (led != 6'b111110) errs++;
    end
    check("steady_lit", errs, 0);

    // release: L stays 15 until the tick at edge 256, then 11/7/3/0/0
    pattern_in = 6'b111111;
    errs = 0;
    while (cyc < 256) begin
      step();
      if (led != 6'b111110) errs++;
    end
    check("hold_until_tick", errs, 0);

    others = 0;
    for (int l = 0; l < 5; l++) begin
      for (int w = 0; w < 4; w++) begin
        window16();
        check($sformatf("decay_L%0d_w%0d", decay_lvl[l], w), lows[0], decay_lvl[l]);
        for (int j = 1; j < N; j++) others += lows[j];
      end
    end
    check("decay_others_off", others, 0);

    // lit sample lands exactly in the tick cycle (edge 639 -> 640)
    run_to(638);
    pattern_in = 6'b111110;
    step();
    pattern_in = 6'b111111;
    step();
    check("simul_pre", int'(led), 32'h3f);
    step();
    check("simul_lit", int'(led), 32'h3e);
    errs = 0;
    while (cyc < 704) begin
      step();
      if (led != 6'b111110) errs++;
    end
    check("simul_full", errs, 0);
    window16();
    check("simul_decay_11", lows[0], 11);

    // reset pulse while L[0] = 7
    run_to(779);
    rst = 1'b1;
    step();
    check("rst_mid_led", int'(led), 32'h3f);
    rst = 1'b0;
    cyc = 0;
    errs = 0;
    repeat (200) begin
      step();
      if (led != 6'b111111) errs++;
    end
    check("no_trail", errs, 0);

    // chaser: rotate just before each tick so the trail shows 16/11/7/3
    rst        = 1'b1;
    pattern_in = 6'b111110;
    pat        = 6'b111110;
    step();
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 7; k++) begin
      run_to(64 * k - 2);
      pat        = {pat[N-2:0], pat[N-1]};
      pattern_in = pat;
      run_to(64 * k);
      window16();
      for (int j = 0; j < N; j++) begin
        int d;
        int exp_lows;
        d = ((k - j) % N + N) % N;
        exp_lows = (d > k) ? 0 : trail_lvl[d];
        check($sformatf("chase_k%0d_led%0d", k, j), lows[j], exp_lows);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
